// File: rtl/noc_pkg.sv
// Shared NoC router definitions: port indices, flit type encoding and small
// helpers used by the per-direction output ports.
package noc_pkg;

    localparam int NUM_PORTS  = 5;
    localparam int PORT_IDX_W = $clog2(NUM_PORTS);

    localparam int DIR_W = 0;
    localparam int DIR_E = 1;
    localparam int DIR_S = 2;
    localparam int DIR_N = 3;
    localparam int DIR_L = 4;

    localparam int FLIT_TYPE_W = 2;

    typedef enum logic [FLIT_TYPE_W-1:0] {
        BODY   = 2'b00,
        TAIL   = 2'b01,
        HEAD   = 2'b10,
        SINGLE = 2'b11
    } flit_type_t;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } port_state_t;

    // The type field sits in the top two bits of a flit of any width.
    function automatic int flit_type_msb(input int flit_w);
        return flit_w - 1;
    endfunction

    function automatic int flit_type_lsb(input int flit_w);
        return flit_w - FLIT_TYPE_W;
    endfunction

    function automatic logic opens_packet(input flit_type_t t);
        return (t == HEAD) || (t == SINGLE);
    endfunction

    function automatic logic [PORT_IDX_W-1:0] onehot_to_idx(input logic [NUM_PORTS-1:0] v);
        logic [PORT_IDX_W-1:0] idx;
        idx = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (v[k]) idx = PORT_IDX_W'(k);
        end
        return idx;
    endfunction

endpackage

// File: rtl/noc_credit_counter.sv
// Downstream credit tracker: starts full, decrements per sent flit, increments
// per returned credit, and flags a credit returned while already full.
module noc_credit_counter #(
    parameter int MAX = 4,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         overflow
);

    assign overflow = inc && !dec && (count == W'(MAX));

    // NOTE: registers are updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= W'(MAX);
        end else if (dec && !inc) begin
            count <= count - W'(1);
        end else if (inc && !dec && !overflow) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/noc_output_port.sv
// One router output direction: picks the turned input head, holds the output
// for a whole wormhole packet, and paces flits by downstream credits.
module noc_output_port
    import noc_pkg::*;
#(
    parameter  int FLIT_W  = 32,
    parameter  int CREDITS = 4,
    localparam int CNT_W   = $clog2(CREDITS + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS-1:0]        turn_i,
    input  logic [NUM_PORTS-1:0]        req_i,
    input  logic [NUM_PORTS*FLIT_W-1:0] flit_i,
    output logic [NUM_PORTS-1:0]        pop_o,
    output logic [FLIT_W-1:0]           flit_o,
    output logic                        valid_o,
    input  logic                        credit_i,
    output logic                        locked_o,
    output logic                        err_o
);

    localparam int TYPE_MSB = flit_type_msb(FLIT_W);
    localparam int TYPE_LSB = flit_type_lsb(FLIT_W);

    port_state_t             state, next_state;
    logic [PORT_IDX_W-1:0]   lock_idx, next_lock_idx;
    logic [PORT_IDX_W-1:0]   sel_idx;
    logic [FLIT_W-1:0]       heads [NUM_PORTS];
    logic [FLIT_W-1:0]       sel_flit;
    flit_type_t              sel_type;
    logic                    grant;
    logic                    proto_err;
    logic [CNT_W-1:0]        credit_cnt;
    logic                    credit_avail;
    logic                    credit_err;

    always_comb begin
        for (int k = 0; k < NUM_PORTS; k++) begin
            heads[k] = flit_i[k*FLIT_W +: FLIT_W];
        end
    end

    // While locked only the owning input is considered; the turn is ignored.
    assign sel_idx      = (state == LOCKED) ? lock_idx : onehot_to_idx(turn_i);
    assign sel_flit     = heads[sel_idx];
    assign sel_type     = flit_type_t'(sel_flit[TYPE_MSB:TYPE_LSB]);
    assign credit_avail = (credit_cnt != '0);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        next_state    = state;
        next_lock_idx = lock_idx;
        grant         = 1'b0;
        proto_err     = 1'b0;
        case (state)
            IDLE: begin
                if ($countones(turn_i) > 1) begin
                    proto_err = 1'b1;
                end else if ((turn_i & req_i) != '0) begin
                    if (!opens_packet(sel_type)) begin
                        proto_err = 1'b1;
                    end else if (credit_avail) begin
                        grant = 1'b1;
                        if (sel_type == HEAD) begin
                            next_state    = LOCKED;
                            next_lock_idx = sel_idx;
                        end
                    end
                end
            end
            LOCKED: begin
                if (req_i[lock_idx]) begin
                    if (opens_packet(sel_type)) begin
                        proto_err = 1'b1;
                    end else if (credit_avail) begin
                        grant = 1'b1;
                        if (sel_type == TAIL) next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        pop_o = '0;
        if (grant && !rst) pop_o[sel_idx] = 1'b1;
    end

    noc_credit_counter #(
        .MAX (CREDITS),
        .W   (CNT_W)
    ) u_credit (
        .clk      (clk),
        .rst      (rst),
        .inc      (credit_i),
        .dec      (grant),
        .count    (credit_cnt),
        .overflow (credit_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            lock_idx <= '0;
            flit_o   <= '0;
            valid_o  <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            state    <= next_state;
            lock_idx <= next_lock_idx;
            valid_o  <= grant;
            if (grant) flit_o <= sel_flit;
            if (proto_err || credit_err) err_o <= 1'b1;
        end
    end

    assign locked_o = (state == LOCKED);

endmodule

// File: tb/tb_noc_output_port.sv
// Self-checking bench for noc_output_port: directed scenarios plus randomized
// traffic compared against a packet-level behavioural model.
module tb_noc_output_port;

    localparam int FW      = 32;
    localparam int CREDITS = 4;
    localparam int NP      = 5;

    logic             clk      = 1'b0;
    logic             rst      = 1'b0;
    logic [NP-1:0]    turn_i   = '0;
    logic [NP-1:0]    req_i    = '0;
    logic [NP*FW-1:0] flit_i   = '0;
    logic             credit_i = 1'b0;
    logic [NP-1:0]    pop_o;
    logic [FW-1:0]    flit_o;
    logic             valid_o;
    logic             locked_o;
    logic             err_o;

    always #5 clk = ~clk;

    noc_output_port #(
        .FLIT_W  (FW),
        .CREDITS (CREDITS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .turn_i   (turn_i),
        .req_i    (req_i),
        .flit_i   (flit_i),
        .pop_o    (pop_o),
        .flit_o   (flit_o),
        .valid_o  (valid_o),
        .credit_i (credit_i),
        .locked_o (locked_o),
        .err_o    (err_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: credits in flight, packet ownership, sticky error.
    int            m_cred;
    bit            m_locked;
    int            m_lock;
    bit            m_err;
    bit            m_valid;
    logic [FW-1:0] m_flit;
    logic [NP-1:0] exp_pop;
    logic [NP-1:0] obs_pop;

    function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [29:0] p);
        return {t, p};
    endfunction

    function automatic logic [NP*FW-1:0] put(input logic [NP*FW-1:0] bus, input int k,
                                             input logic [FW-1:0] f);
        logic [NP*FW-1:0] b;
        b = bus;
        b[k*FW +: FW] = f;
        return b;
    endfunction

    task automatic model_reset();
        m_cred   = CREDITS;
        m_locked = 1'b0;
        m_lock   = 0;
        m_err    = 1'b0;
        m_valid  = 1'b0;
        m_flit   = '0;
    endtask

    task automatic model_cycle(input logic [NP-1:0] turn, input logic [NP-1:0] req,
                               input logic [NP*FW-1:0] flits, input logic credit);
        int         ones, k, g;
        logic [1:0] t;
        bit         perr, cerr, send;
        ones = 0; k = 0; g = -1; perr = 0;
        for (int i = 0; i < NP; i++) if (turn[i]) begin ones++; k = i; end
        if (m_locked) k = m_lock;
        t = flits[k*FW + FW-2 +: 2];
        if (!m_locked) begin
            if (ones > 1) perr = 1;
            else if (ones == 1 && req[k]) begin
                if (!t[1]) perr = 1;
                else if (m_cred > 0) g = k;
            end
        end else if (req[k]) begin
            if (t[1]) perr = 1;
            else if (m_cred > 0) g = k;
        end
        send    = (g >= 0);
        cerr    = credit && !send && (m_cred == CREDITS);
        exp_pop = '0;
        if (send) begin
            exp_pop[g] = 1'b1;
            m_flit     = flits[g*FW +: FW];
            if (!m_locked && t == 2'b10) begin
                m_locked = 1;
                m_lock   = g;
            end else if (m_locked && t == 2'b01) begin
                m_locked = 0;
            end
        end
        m_valid = send;
        m_cred  = m_cred - (send ? 1 : 0) + ((credit && !cerr) ? 1 : 0);
        if (perr || cerr) m_err = 1;
    endtask

    // Drives one cycle, samples the combinational pop, then lands 1 ns past the edge.
    task automatic step(input logic [NP-1:0] turn, input logic [NP-1:0] req,
                        input logic [NP*FW-1:0] flits, input logic credit);
        turn_i   = turn;
        req_i    = req;
        flit_i   = flits;
        credit_i = credit;
        #1;
        obs_pop = pop_o;
        model_cycle(turn, req, flits, credit);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        turn_i = 5'b01000;
        req_i  = 5'b01000;
        flit_i = put('0, 3, mk(2'b11, 30'h55));
        #2 rst = 1'b1;
        #1;
        n_checks++; if (pop_o !== 5'b0) $display("FAIL reset_pop got %b want 00000", pop_o); else n_pass++;
        n_checks++; if (valid_o !== 1'b0) $display("FAIL reset_valid got %b want 0", valid_o); else n_pass++;
        n_checks++; if (flit_o !== '0) $display("FAIL reset_flit got %h want 0", flit_o); else n_pass++;
        n_checks++; if (locked_o !== 1'b0) $display("FAIL reset_locked got %b want 0", locked_o); else n_pass++;
        n_checks++; if (err_o !== 1'b0) $display("FAIL reset_err got %b want 0", err_o); else n_pass++;
        @(posedge clk);
        #1;
        n_checks++; if (pop_o !== 5'b0) $display("FAIL reset_pop_edge got %b want 00000", pop_o); else n_pass++;
        n_checks++; if (valid_o !== 1'b0) $display("FAIL reset_valid_edge got %b want 0", valid_o); else n_pass++;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_single();
        step(5'b01000, 5'b01000, put('0, 3, mk(2'b11, 30'h1234)), 1'b0);
        n_checks++; if (obs_pop !== 5'b01000) $display("FAIL single_pop got %b want 01000", obs_pop); else n_pass++;
        n_checks++; if (valid_o !== 1'b1) $display("FAIL single_valid got %b want 1", valid_o); else n_pass++;
        n_checks++; if (flit_o !== 32'hC000_1234) $display("FAIL single_flit got %h want c0001234", flit_o); else n_pass++;
        n_checks++; if (locked_o !== 1'b0) $display("FAIL single_locked got %b want 0", locked_o); else n_pass++;
        step(5'b00000, 5'b00000, '0, 1'b0);
        n_checks++; if (valid_o !== 1'b0) $display("FAIL single_idle_valid got %b want 0", valid_o); else n_pass++;
        n_checks++; if (flit_o !== 32'hC000_1234) $display("FAIL single_hold_flit got %h want c0001234", flit_o); else n_pass++;
    endtask

    task automatic test_wormhole();
        logic [NP-1:0]    turns [4];
        logic [1:0]       types [4];
        logic [NP*FW-1:0] flits;
        turns = '{5'b00001, 5'b01000, 5'b10000, 5'b00010};
        types = '{2'b10, 2'b00, 2'b00, 2'b01};
        apply_reset();
        for (int c = 0; c < 4; c++) begin
            flits = put('0, 1, mk(2'b11, 30'h100));
            flits = put(flits, 3, mk(2'b11, 30'h300));
            flits = put(flits, 4, mk(2'b10, 30'h400));
            flits = put(flits, 0, mk(types[c], 30'(c + 7)));
            step(turns[c], 5'b11011, flits, 1'b0);
            n_checks++; if (obs_pop !== 5'b00001) $display("FAIL worm_pop c%0d got %b want 00001", c, obs_pop); else n_pass++;
            n_checks++; if (flit_o !== m_flit) $display("FAIL worm_flit c%0d got %h want %h", c, flit_o, m_flit); else n_pass++;
            n_checks++; if (locked_o !== (c < 3)) $display("FAIL worm_locked c%0d got %b want %b", c, locked_o, (c < 3)); else n_pass++;
            n_checks++; if (err_o !== 1'b0) $display("FAIL worm_err c%0d got %b want 0", c, err_o); else n_pass++;
        end
    endtask

    task automatic test_credit_stall();
        bit rq   [12];
        bit cr   [12];
        bit gnt  [12];
        rq  = '{1,1,1,1,1,0,1,1,0,1,1,1};
        cr  = '{0,0,0,0,0,1,0,0,1,1,0,0};
        gnt = '{1,1,1,1,0,0,1,0,0,1,1,0};
        apply_reset();
        for (int c = 0; c < 12; c++) begin
            step(5'b01000, rq[c] ? 5'b01000 : 5'b00000, put('0, 3, mk(2'b11, 30'(c + 32))), cr[c]);
            n_checks++; if (obs_pop !== (gnt[c] ? 5'b01000 : 5'b00000)) $display("FAIL credit_pop c%0d got %b want %b", c, obs_pop, gnt[c] ? 5'b01000 : 5'b00000); else n_pass++;
            n_checks++; if (valid_o !== gnt[c]) $display("FAIL credit_valid c%0d got %b want %b", c, valid_o, gnt[c]); else n_pass++;
            n_checks++; if (flit_o !== m_flit) $display("FAIL credit_flit c%0d got %h want %h", c, flit_o, m_flit); else n_pass++;
            n_checks++; if (err_o !== 1'b0) $display("FAIL credit_err c%0d got %b want 0", c, err_o); else n_pass++;
        end
    endtask

    task automatic test_errors();
        apply_reset();
        step(5'b00000, 5'b00100, put('0, 2, mk(2'b11, 30'h1)), 1'b0);
        n_checks++; if (err_o !== 1'b0) $display("FAIL err_zero_turn got %b want 0", err_o); else n_pass++;
        step(5'b00000, 5'b00000, '0, 1'b1);
        n_checks++; if (err_o !== 1'b1) $display("FAIL err_credit_overflow got %b want 1", err_o); else n_pass++;
        step(5'b00000, 5'b00000, '0, 1'b0);
        n_checks++; if (err_o !== 1'b1) $display("FAIL err_sticky got %b want 1", err_o); else n_pass++;

        apply_reset();
        step(5'b00011, 5'b00011, put(put('0, 0, mk(2'b11, 30'h2)), 1, mk(2'b11, 30'h3)), 1'b0);
        n_checks++; if (obs_pop !== 5'b0) $display("FAIL err_multihot_pop got %b want 00000", obs_pop); else n_pass++;
        n_checks++; if (valid_o !== 1'b0) $display("FAIL err_multihot_valid got %b want 0", valid_o); else n_pass++;
        n_checks++; if (err_o !== 1'b1) $display("FAIL err_multihot got %b want 1", err_o); else n_pass++;

        apply_reset();
        step(5'b00100, 5'b00100, put('0, 2, mk(2'b00, 30'h4)), 1'b0);
        n_checks++; if (obs_pop !== 5'b0) $display("FAIL err_body_pop got %b want 00000", obs_pop); else n_pass++;
        n_checks++; if (err_o !== 1'b1) $display("FAIL err_body_idle got %b want 1", err_o); else n_pass++;
    endtask

    task automatic test_reset_mid_packet();
        apply_reset();
        step(5'b00001, 5'b00001, put('0, 0, mk(2'b10, 30'h10)), 1'b0);
        step(5'b00000, 5'b00001, put('0, 0, mk(2'b00, 30'h11)), 1'b0);
        n_checks++; if (locked_o !== 1'b1) $display("FAIL mid_locked_before got %b want 1", locked_o); else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++; if (locked_o !== 1'b0) $display("FAIL mid_locked got %b want 0", locked_o); else n_pass++;
        n_checks++; if (valid_o !== 1'b0) $display("FAIL mid_valid got %b want 0", valid_o); else n_pass++;
        n_checks++; if (flit_o !== '0) $display("FAIL mid_flit got %h want 0", flit_o); else n_pass++;
        n_checks++; if (pop_o !== 5'b0) $display("FAIL mid_pop got %b want 00000", pop_o); else n_pass++;
        #1;
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 5; c++) begin
            step(5'b10000, 5'b10000, put('0, 4, mk(2'b11, 30'(c))), 1'b0);
            n_checks++; if (obs_pop !== ((c < 4) ? 5'b10000 : 5'b00000)) $display("FAIL mid_refill_pop c%0d got %b want %b", c, obs_pop, (c < 4) ? 5'b10000 : 5'b00000); else n_pass++;
            n_checks++; if (valid_o !== m_valid) $display("FAIL mid_refill_valid c%0d got %b want %b", c, valid_o, m_valid); else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [NP-1:0]    turn, req;
        logic [NP*FW-1:0] flits;
        logic             credit;
        logic [1:0]       t;
        int               sel;
        bit               in_pkt, wrong;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cyc % 80 == 0) apply_reset();
            sel = $urandom_range(0, 49);
            if (sel == 0) turn = '0;
            else if (sel == 1) turn = 5'b00011 << $urandom_range(0, 3);
            else turn = 5'b00001 << $urandom_range(0, 4);
            req   = 5'($urandom);
            flits = '0;
            for (int k = 0; k < NP; k++) begin
                in_pkt = m_locked && (k == m_lock);
                wrong  = ($urandom_range(0, 39) == 0);
                if (in_pkt ^ wrong) t = ($urandom_range(0, 3) == 0) ? 2'b01 : 2'b00;
                else t = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11;
                flits = put(flits, k, mk(t, 30'($urandom)));
            end
            credit = (m_cred < CREDITS) && ($urandom_range(0, 2) == 0);
            step(turn, req, flits, credit);
            n_checks++; if (obs_pop !== exp_pop) $display("FAIL rnd_pop cyc%0d got %b want %b", cyc, obs_pop, exp_pop); else n_pass++;
            n_checks++; if (valid_o !== m_valid) $display("FAIL rnd_valid cyc%0d got %b want %b", cyc, valid_o, m_valid); else n_pass++;
            n_checks++; if (flit_o !== m_flit) $display("FAIL rnd_flit cyc%0d got %h want %h", cyc, flit_o, m_flit); else n_pass++;
            n_checks++; if (locked_o !== m_locked) $display("FAIL rnd_locked cyc%0d got %b want %b", cyc, locked_o, m_locked); else n_pass++;
            n_checks++; if (err_o !== m_err) $display("FAIL rnd_err cyc%0d got %b want %b", cyc, err_o, m_err); else n_pass++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_wormhole();
        test_credit_stall();
        test_errors();
        test_reset_mid_packet();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
